// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// The requester (master) drives the operands and start; the subtractor
// (slave) returns busy/done, the difference and the status flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin_init,
    input  busy, done, d, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin_init,
    output busy, done, d, bout, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin_init, one full-subtractor cell
// evaluated per clock, LSB first. The borrow lives in a flop between bits.
// Result and flags are published together on the edge that processes the
// MSB and then held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             brw_q, brw_d;

  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // FSM-decoded strobes
  logic             busy_s;
  logic             load_s;
  logic             finish_s;

  // Single full-subtractor cell on the current LSBs
  logic             diff_bit;
  logic             brw_new;
  logic [WIDTH-1:0] d_asm;
  logic             last_bit;

  assign diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
  assign brw_new  = (~a_sh_q[0] & (b_sh_q[0] ^ brw_q)) | (b_sh_q[0] & brw_q);
  assign d_asm    = {diff_bit, d_sh_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, return to IDLE after the MSB
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last_bit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: busy level plus load/finish strobes for the datapath
  always_comb begin
    busy_s   = 1'b0;
    load_s   = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      IDLE: load_s = bus.start;
      RUN: begin
        busy_s   = 1'b1;
        finish_s = last_bit;
      end
      default: ;
    endcase
  end

  // Datapath next-state: load operands, shift one bit per cycle, publish on finish
  always_comb begin
    cnt_d  = cnt_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    d_sh_d = d_sh_q;
    brw_d  = brw_q;
    d_d    = d_q;
    bout_d = bout_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    done_d = finish_s;

    if (load_s) begin
      a_sh_d = bus.a;
      b_sh_d = bus.b;
      brw_d  = bus.bin_init;
      cnt_d  = '0;
    end else if (busy_s) begin
      a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
      d_sh_d = d_asm;
      brw_d  = brw_new;
      // The counter stops at WIDTH-1 and is reloaded on the next accept.
      if (!last_bit) cnt_d = cnt_q + CW'(1);
    end

    if (finish_s) begin
      d_d    = d_asm;
      bout_d = brw_new;
      // Borrow into the MSB is the borrow flop before this edge.
      ovf_d  = brw_q ^ brw_new;
      zero_d = (d_asm == '0);
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      d_sh_q <= '0;
      brw_q  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      d_sh_q <= d_sh_d;
      brw_q  <= brw_d;
      d_q    <= d_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign bus.busy = busy_s;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a cycle-level behavioural model (operation
// latency counter plus whole-word arithmetic) checked against the DUT on
// every cycle, plus directed vectors with hand-computed expectations.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             m_rem = 0;      // cycles left in the current operation
  logic [W-1:0]   m_d = '0;
  logic           m_bout = 1'b0;
  logic           m_zero = 1'b0;
  logic           m_ovf = 1'b0;
  logic           m_done = 1'b0;
  logic [W-1:0]   p_d;
  logic           p_bout, p_zero, p_ovf;

  task automatic compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic z, output logic ov);
    logic [W:0] full;
    int sa, sb, s;
    full = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    d    = full[W-1:0];
    bo   = full[W];
    z    = (full[W-1:0] == '0);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    s    = sa - sb - int'(bin);
    ov   = (s < -(2 ** (W-1))) || (s > (2 ** (W-1)) - 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_rem  = 0;
        m_d    = '0;
        m_bout = 1'b0;
        m_zero = 1'b0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_d    = p_d;
            m_bout = p_bout;
            m_zero = p_zero;
            m_ovf  = p_ovf;
            m_done = 1'b1;
          end
        end else if (bus.start) begin
          compute(bus.a, bus.b, bus.bin_init, p_d, p_bout, p_zero, p_ovf);
          m_rem = W;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_busy", 32'(bus.busy), 32'(m_rem > 0));
      check("cyc_done", 32'(bus.done), 32'(m_done));
      check("cyc_d",    32'(bus.d),    32'(m_d));
      check("cyc_bout", 32'(bus.bout), 32'(m_bout));
      check("cyc_zero", 32'(bus.zero), 32'(m_zero));
      check("cyc_ovf",  32'(bus.ovf),  32'(m_ovf));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo);
    int n;
    int busy_cnt;
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin_init = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;       // operands may change after acceptance
    bus.b     = ~b;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < W + 4) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check("op_done_seen", 32'(bus.done), 32'd1);
    check("op_busy_cycles", 32'(busy_cnt), 32'(W));
    check("op_d",    32'(bus.d),    32'(ed));
    check("op_bout", 32'(bus.bout), 32'(eb));
    check("op_zero", 32'(bus.zero), 32'(ez));
    check("op_ovf",  32'(bus.ovf),  32'(eo));
    check("model_d", 32'(m_d),      32'(ed));
    check("model_flags", {29'd0, m_bout, m_zero, m_ovf}, {29'd0, eb, ez, eo});
    $display("op a=%02h b=%02h bin=%0d -> d=%02h bout=%0d zero=%0d ovf=%0d", a, b, bin,
             bus.d, bus.bout, bus.zero, bus.ovf);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int last_done;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.bin_init = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_d",    32'(bus.d),    32'd0);
    check("rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
    @(negedge clk);

    // Directed vectors
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Start during RUN is ignored
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11; bus.bin_init = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("ignore_single_done", 32'(dones), 32'd1);
    check("ignore_d", 32'(bus.d), 32'h22);
    $display("ignore test: dones=%0d d=%02h", dones, bus.d);
    for (int i = 0; i < 20; i++) begin
      check("hold_d", 32'(bus.d), 32'h22);
      @(negedge clk);
    end

    // Reset mid-operation aborts
    bus.start = 1'b1; bus.a = 8'h44; bus.b = 8'h11; bus.bin_init = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_d",    32'(bus.d),    32'd0);
    check("abort_flags", {29'd0, bus.done, bus.bout, bus.zero}, 32'd0);
    check("abort_ovf",  32'(bus.ovf),  32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dones), 32'd0);
    $display("abort test: dones=%0d d=%02h", dones, bus.d);
    run_op(8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Back-to-back random operations with start held high
    dones = 0;
    last_done = -1;
    bus.start = 1'b1;
    for (int i = 0; i < 200 * (W + 1); i++) begin
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.bin_init = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (last_done >= 0) check("b2b_spacing", 32'(i - last_done), 32'(W + 1));
        last_done = i;
      end
    end
    bus.start = 1'b0;
    check("b2b_done_count", 32'(dones), 32'd200);
    $display("back-to-back: %0d operations completed", dones);
    repeat (W + 2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
